// File: rtl/qd_pkg.sv
// Shared quadrature state encoding and up-order successor used by the decoder.
package qd_pkg;

    typedef enum logic [1:0] {
        QD_S00 = 2'b00,
        QD_S01 = 2'b01,
        QD_S11 = 2'b11,
        QD_S10 = 2'b10
    } qd_state_e;

    // Up order 00->01->11->10->00 (B leads A); down order is the reverse.
    function automatic qd_state_e qd_next_up(input qd_state_e state);
        case (state)
            QD_S00:  return QD_S01;
            QD_S01:  return QD_S11;
            QD_S11:  return QD_S10;
            default: return QD_S00;
        endcase
    endfunction

endpackage

// File: rtl/qd_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: a level must hold
// for FILTER_LEN clocks at the synchroniser output before it is accepted.
module qd_glitch_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic q_filt
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          s1_q;
    logic          s2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= d_async;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q_filt = filt_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: filtered inputs, registered step/up/error pulses,
// sticky error flag and an N-bit wrapping position count.
module quadrature_decoder
    import qd_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         clear,
    input  logic         a_in,
    input  logic         b_in,
    output logic         step,
    output logic         up,
    output logic         error,
    output logic         err_flag,
    output logic [N-1:0] position
);

    localparam int unsigned PRIME_CNT = FILTER_LEN + 2;
    localparam int unsigned PW        = $clog2(PRIME_CNT + 1);

    logic          filt_a;
    logic          filt_b;
    qd_state_e     cur_state;
    qd_state_e     prev_q, prev_d;
    logic          step_q, step_d;
    logic          up_q, up_d;
    logic          error_q, error_d;
    logic          err_flag_q, err_flag_d;
    logic          primed_q, primed_d;
    logic [PW-1:0] start_q, start_d;
    logic [N-1:0]  pos_q, pos_d;
    logic          is_up, is_down, is_err, live;

    qd_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .d_async (a_in),
        .q_filt  (filt_a)
    );

    qd_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .d_async (b_in),
        .q_filt  (filt_b)
    );

    always_comb begin
        cur_state = qd_state_e'({filt_a, filt_b});
        prev_d    = cur_state;

        // Priming outlasts the filter's first settle so the initial level is absorbed silently.
        start_d  = start_q;
        primed_d = primed_q;
        if (!primed_q) begin
            if (start_q == PW'(PRIME_CNT)) begin
                primed_d = 1'b1;
            end else begin
                start_d = start_q + PW'(1);
            end
        end

        is_up   = (qd_next_up(prev_q) == cur_state);
        is_down = (qd_next_up(cur_state) == prev_q);
        is_err  = (cur_state != prev_q) && !is_up && !is_down;
        live    = primed_q && enable;

        step_d  = live && (is_up || is_down);
        error_d = live && is_err;
        up_d    = step_d ? is_up : up_q;

        pos_d = pos_q;
        if (step_d) begin
            pos_d = is_up ? pos_q + N'(1) : pos_q - N'(1);
        end
        if (clear) begin
            pos_d = '0;
        end

        err_flag_d = err_flag_q;
        if (error_d) begin
            err_flag_d = 1'b1;
        end
        if (clear) begin
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= QD_S00;
            step_q     <= 1'b0;
            up_q       <= 1'b0;
            error_q    <= 1'b0;
            err_flag_q <= 1'b0;
            primed_q   <= 1'b0;
            start_q    <= '0;
            pos_q      <= '0;
        end else begin
            prev_q     <= prev_d;
            step_q     <= step_d;
            up_q       <= up_d;
            error_q    <= error_d;
            err_flag_q <= err_flag_d;
            primed_q   <= primed_d;
            start_q    <= start_d;
            pos_q      <= pos_d;
        end
    end

    assign step     = step_q;
    assign up       = up_q;
    assign error    = error_q;
    assign err_flag = err_flag_q;
    assign position = pos_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: stimulus queues expected step/error
// events, a monitor pops and compares whenever step or error is asserted.
module tb_quadrature_decoder;

    localparam int N  = 16;
    localparam int FL = 4;

    logic         clk = 1'b0;
    logic         reset, enable, clear, a_in, b_in;
    logic         step, up, error, err_flag;
    logic [N-1:0] position;

    typedef struct {
        logic        is_err;
        logic        up;
        logic [15:0] pos;
        logic        ef;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    quadrature_decoder #(.N(N), .FILTER_LEN(FL)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .a_in     (a_in),
        .b_in     (b_in),
        .step     (step),
        .up       (up),
        .error    (error),
        .err_flag (err_flag),
        .position (position)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic expect_ev(input logic is_err, input logic e_up, input logic [15:0] pos, input logic ef);
        exp_t e;
        e.is_err = is_err;
        e.up     = e_up;
        e.pos    = pos;
        e.ef     = ef;
        exp_q.push_back(e);
    endtask

    // Set A/B at a falling edge and hold for 'hold' rising edges; clear is high
    // for rising edge number clr_edge (0 = never). lat = first edge with step/error.
    task automatic drive(input logic a, input logic b, input int hold, input int clr_edge,
                         output int lt);
        @(negedge clk);
        a_in = a;
        b_in = b;
        lt   = 0;
        for (int i = 1; i <= hold; i++) begin
            if (i > 1) @(negedge clk);
            clear = (i == clr_edge);
            @(posedge clk);
            #1;
            if (lt == 0 && (step === 1'b1 || error === 1'b1)) lt = i;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset === 1'b0 && (step === 1'b1 || error === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: step=%0b error=%0b pos=%0h, expected no event",
                         step, error, position);
            end else begin
                e = exp_q.pop_front();
                check("mon_step", step, !e.is_err);
                check("mon_error", error, e.is_err);
                check("mon_up", up, e.up);
                check("mon_pos", position, e.pos);
                check("mon_err_flag", err_flag, e.ef);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        clear  = 1'b0;
        a_in   = 1'b1;
        b_in   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_step", step, 0);
        check("rst_error", error, 0);
        check("rst_up", up, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_pos", position, 0);

        // 1: inputs high through reset settle silently while unprimed
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t1_step", step, 0);
        check("t1_error", error, 0);
        check("t1_pos", position, 0);
        check("t1_err_flag", err_flag, 0);

        // reset mid-operation back to 00
        reset = 1'b1;
        a_in  = 1'b0;
        b_in  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        // 2: up sequence
        expect_ev(0, 1, 16'h0001, 0); drive(0, 1, 8, 0, lat);
        check("t2_latency", lat, 7);
        expect_ev(0, 1, 16'h0002, 0); drive(1, 1, 8, 0, lat);
        expect_ev(0, 1, 16'h0003, 0); drive(1, 0, 8, 0, lat);
        expect_ev(0, 1, 16'h0004, 0); drive(0, 0, 8, 0, lat);
        wait_drain("t2_drain");
        @(negedge clk);
        check("t2_pos", position, 16'h0004);
        check("t2_up", up, 1);

        // 3: down sequence from 0, wrapping
        pulse_clear();
        check("t3_clr_pos", position, 0);
        expect_ev(0, 0, 16'hFFFF, 0); drive(1, 0, 8, 0, lat);
        expect_ev(0, 0, 16'hFFFE, 0); drive(1, 1, 8, 0, lat);
        expect_ev(0, 0, 16'hFFFD, 0); drive(0, 1, 8, 0, lat);
        expect_ev(0, 0, 16'hFFFC, 0); drive(0, 0, 8, 0, lat);
        wait_drain("t3_drain");
        @(negedge clk);
        check("t3_up", up, 0);

        // 4: 3-clock glitch rejected, 4-clock level accepted
        drive(1, 0, 3, 0, lat);
        drive(0, 0, 12, 0, lat);
        check("t4_glitch", lat, 0);
        expect_ev(0, 0, 16'hFFFB, 0); drive(1, 0, 12, 0, lat);
        wait_drain("t4_drain_a");
        expect_ev(0, 1, 16'hFFFC, 0); drive(0, 0, 8, 0, lat);
        wait_drain("t4_drain_b");

        // 5: illegal 00->11
        expect_ev(1, 1, 16'hFFFC, 1); drive(1, 1, 8, 0, lat);
        check("t5_err_latency", lat, 7);
        wait_drain("t5_drain");
        @(negedge clk);
        check("t5_err_flag", err_flag, 1);
        check("t5_error_low", error, 0);
        pulse_clear();
        check("t5_err_flag_clr", err_flag, 0);
        check("t5_pos_clr", position, 0);
        expect_ev(0, 1, 16'h0001, 0); drive(1, 0, 8, 0, lat);
        expect_ev(0, 1, 16'h0002, 0); drive(0, 0, 8, 0, lat);
        wait_drain("t5_drain_b");

        // 6: enable low suppresses steps, then clear coincident with a step
        @(negedge clk);
        enable = 1'b0;
        drive(0, 1, 8, 0, lat);
        drive(1, 1, 8, 0, lat);
        check("t6_dis_lat", lat, 0);
        check("t6_dis_pos", position, 16'h0002);
        @(negedge clk);
        enable = 1'b1;
        drive(1, 1, 8, 0, lat);
        check("t6_no_spurious", lat, 0);
        expect_ev(0, 1, 16'h0000, 0); drive(1, 0, 8, 7, lat);
        check("t6_clr_step_lat", lat, 7);
        wait_drain("t6_drain");
        check("t6_pos", position, 0);
        expect_ev(0, 1, 16'h0001, 0); drive(0, 0, 8, 0, lat);
        wait_drain("t6_drain_b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
